// File: rtl/sigmoid_seq_if.sv
// Handshake and shared-arithmetic bus for sigmoid_seq.
// master is the sequencer side; slave is the accumulator/consumer/arithmetic side.
interface sigmoid_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_y;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_out;
  logic        busy;

  modport master (
    input  in_valid, x, out_ready, mul_y, add_out,
    output in_ready, out_valid, y, mul_a, mul_b, add_a, add_b, busy
  );

  modport slave (
    output in_valid, x, out_ready, mul_y, add_out,
    input  in_ready, out_valid, y, mul_a, mul_b, add_a, add_b, busy
  );
endinterface

// File: rtl/sigmoid_seq.sv
// Piecewise-linear sigmoid sequenced over one shared FP multiplier and one shared FP adder.
// Negative inputs are folded as y = 1 - y(|x|).
module sigmoid_seq #(
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned ADD_LAT = 1
) (
  input logic           clk,
  input logic           rst,
  sigmoid_seq_if.master bus
);

  localparam int unsigned MaxLat = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
  localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;
  localparam logic [CntW-1:0] MulLast = CntW'(MUL_LAT - 1);
  localparam logic [CntW-1:0] AddLast = CntW'(ADD_LAT - 1);
  localparam logic [31:0] FpOne = 32'h3F80_0000;

  typedef enum logic [2:0] {StIdle, StMul, StAdd, StNeg, StDone} state_e;
  typedef enum logic [1:0] {SegLow, SegMid, SegHigh} seg_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sgn_q, sgn_d;
  logic [30:0]     mag_q, mag_d;
  seg_e            seg_q, seg_d;
  logic [31:0]     prod_q, prod_d;
  logic [30:0]     ypos_q, ypos_d;
  logic [31:0]     y_q, y_d;
  logic [31:0]     slope, offset;
  logic [30:0]     in_mag;

  assign in_mag = bus.x[30:0];

  always_comb begin
    slope  = 32'h3E80_0000;
    offset = 32'h3F00_0000;
    unique case (seg_q)
      SegHigh: begin
        slope  = 32'h3D00_0000;
        offset = 32'h3F58_0000;
      end
      SegMid: begin
        slope  = 32'h3E00_0000;
        offset = 32'h3F20_0000;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    mag_d   = mag_q;
    seg_d   = seg_q;
    prod_d  = prod_q;
    ypos_d  = ypos_q;
    y_d     = y_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          sgn_d = bus.x[31];
          mag_d = in_mag;
          // Unsigned compare on the magnitude orders IEEE singles correctly.
          if (in_mag > 31'h7F80_0000) begin
            y_d     = 32'h7FC0_0000;
            state_d = StDone;
          end else if (in_mag >= 31'h40A0_0000) begin
            y_d     = bus.x[31] ? 32'h0 : FpOne;
            state_d = StDone;
          end else begin
            state_d = StMul;
            if (in_mag >= 31'h4018_0000)      seg_d = SegHigh;
            else if (in_mag >= 31'h3F80_0000) seg_d = SegMid;
            else                              seg_d = SegLow;
          end
        end
      end
      StMul: begin
        if (cnt_q == MulLast) begin
          prod_d  = bus.mul_y;
          state_d = StAdd;
        end
      end
      StAdd: begin
        if (cnt_q == AddLast) begin
          ypos_d = bus.add_out[30:0];
          if (sgn_q) begin
            state_d = StNeg;
          end else begin
            y_d     = bus.add_out;
            state_d = StDone;
          end
        end
      end
      StNeg: begin
        if (cnt_q == AddLast) begin
          y_d     = {1'b0, bus.add_out[30:0]};
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Reload on every state entry; only the wait states count.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == StMul || state_q == StAdd || state_q == StNeg) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      mag_q   <= '0;
      seg_q   <= SegLow;
      prod_q  <= '0;
      ypos_q  <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      mag_q   <= mag_d;
      seg_q   <= seg_d;
      prod_q  <= prod_d;
      ypos_q  <= ypos_d;
      y_q     <= y_d;
    end
  end

  // Operands decode from the state register so reset clears them asynchronously.
  always_comb begin
    bus.mul_a = '0;
    bus.mul_b = '0;
    bus.add_a = '0;
    bus.add_b = '0;
    unique case (state_q)
      StMul: begin
        bus.mul_a = {1'b0, mag_q};
        bus.mul_b = slope;
      end
      StAdd: begin
        bus.add_a = prod_q;
        bus.add_b = offset;
      end
      StNeg: begin
        bus.add_a = FpOne;
        bus.add_b = {1'b1, ypos_q};
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.y         = y_q;

endmodule

// File: tb/tb_sigmoid_seq.sv
// Bench for sigmoid_seq: two instances (1/1 and 3/2 latencies) driven by behavioural FP units
// that return junk until their operands have been stable for the configured latency.
module tb_sigmoid_seq;

  localparam int M0 = 1;
  localparam int A0 = 1;
  localparam int M1 = 3;
  localparam int A1 = 2;
  localparam logic [31:0] Junk = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  int tests = 0;
  int fails = 0;

  sigmoid_seq_if if0 ();
  sigmoid_seq_if if1 ();

  sigmoid_seq #(.MUL_LAT(M0), .ADD_LAT(A0)) dut0 (.clk(clk), .rst(rst0), .bus(if0));
  sigmoid_seq #(.MUL_LAT(M1), .ADD_LAT(A1)) dut1 (.clk(clk), .rst(rst1), .bus(if1));

  always #5 clk = ~clk;

  function automatic real p2(input int e);
    real r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else repeat (-e) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(input logic [31:0] b);
    real m;
    if (b[30:0] == 31'h0) return 0.0;
    m = (1.0 + real'(b[22:0]) / 8388608.0) * p2(int'(b[30:23]) - 127);
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  // Reference sigmoid straight from the piecewise definition in real arithmetic.
  function automatic logic [31:0] ref_y(input logic [31:0] xv);
    real a;
    real r;
    if (xv[30:0] > 31'h7F80_0000) return 32'h7FC0_0000;
    a = f2r({1'b0, xv[30:0]});
    if (a >= 5.0)        r = 1.0;
    else if (a >= 2.375) r = a / 32.0 + 0.84375;
    else if (a >= 1.0)   r = a / 8.0 + 0.625;
    else                 r = a / 4.0 + 0.5;
    if (xv[31]) r = 1.0 - r;
    return r2f(r);
  endfunction

  // Edges after the accept edge until out_valid rises; direct-to-DONE inputs rise on the accept edge.
  function automatic int ref_lat(input logic [31:0] xv, input int ml, input int al);
    if (xv[30:0] > 31'h7F80_0000 || f2r({1'b0, xv[30:0]}) >= 5.0) return 0;
    return ml + al + (xv[31] ? al : 0);
  endfunction

  // Short mantissas keep every intermediate exactly representable.
  function automatic logic [31:0] rand_x();
    logic [7:0] e;
    logic [7:0] m;
    e = 8'(117 + $urandom_range(0, 12));
    m = 8'($urandom_range(0, 255));
    if ($urandom_range(0, 9) == 0) return {1'($urandom_range(0, 1)), 8'hFF, m, 15'h0};
    return {1'($urandom_range(0, 1)), e, m, 15'h0};
  endfunction

  // Arithmetic unit models: value valid once operands held for LAT cycles.
  logic [31:0] m0_pa = '0, m0_pb = '0, a0_pa = '0, a0_pb = '0;
  logic [31:0] m1_pa = '0, m1_pb = '0, a1_pa = '0, a1_pb = '0;
  int m0_c = 0, a0_c = 0, m1_c = 0, a1_c = 0;
  int m0_s, a0_s, m1_s, a1_s;

  assign m0_s = (if0.mul_a == m0_pa && if0.mul_b == m0_pb) ? m0_c + 1 : 0;
  assign a0_s = (if0.add_a == a0_pa && if0.add_b == a0_pb) ? a0_c + 1 : 0;
  assign m1_s = (if1.mul_a == m1_pa && if1.mul_b == m1_pb) ? m1_c + 1 : 0;
  assign a1_s = (if1.add_a == a1_pa && if1.add_b == a1_pb) ? a1_c + 1 : 0;

  always @(posedge clk) begin
    m0_c <= m0_s; m0_pa <= if0.mul_a; m0_pb <= if0.mul_b;
    a0_c <= a0_s; a0_pa <= if0.add_a; a0_pb <= if0.add_b;
    m1_c <= m1_s; m1_pa <= if1.mul_a; m1_pb <= if1.mul_b;
    a1_c <= a1_s; a1_pa <= if1.add_a; a1_pb <= if1.add_b;
  end

  assign if0.mul_y   = (m0_s >= M0 - 1) ? fmul(if0.mul_a, if0.mul_b) : Junk;
  assign if0.add_out = (a0_s >= A0 - 1) ? fadd(if0.add_a, if0.add_b) : Junk;
  assign if1.mul_y   = (m1_s >= M1 - 1) ? fmul(if1.mul_a, if1.mul_b) : Junk;
  assign if1.add_out = (a1_s >= A1 - 1) ? fadd(if1.add_a, if1.add_b) : Junk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(virtual sigmoid_seq_if vif, input logic [31:0] xv, input logic [31:0] ey,
                     input int el, input string tag);
    int lat;
    chk({tag, "_in_ready"}, {31'b0, vif.in_ready}, 32'd1);
    vif.out_ready = 1'b1;
    vif.in_valid  = 1'b1;
    vif.x         = xv;
    @(negedge clk);
    vif.in_valid = 1'b0;
    vif.x        = $urandom;
    if (el > 0) chk({tag, "_mul_a"}, vif.mul_a, {1'b0, xv[30:0]});
    lat = 0;
    while (vif.out_valid !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(el));
    chk({tag, "_y"}, vif.y, ey);
    chk({tag, "_busy"}, {31'b0, vif.busy}, 32'd1);
    chk({tag, "_ops_idle"}, vif.mul_a | vif.mul_b | vif.add_a | vif.add_b, 32'h0);
    @(negedge clk);
    chk({tag, "_after_hs"}, {31'b0, vif.out_valid}, 32'd0);
  endtask

  logic [31:0] dx [10];
  logic [31:0] dy [10];
  int          dl [10];

  initial begin
    int lat;
    logic [31:0] xv;
    bit seen;

    dx = '{32'h3F00_0000, 32'hBF00_0000, 32'h3F80_0000, 32'h4040_0000, 32'h4018_0000,
           32'h40A0_0000, 32'hC0C0_0000, 32'h7FC0_0001, 32'h7F80_0000, 32'h8000_0000};
    dy = '{32'h3F20_0000, 32'h3EC0_0000, 32'h3F40_0000, 32'h3F70_0000, 32'h3F6B_0000,
           32'h3F80_0000, 32'h0000_0000, 32'h7FC0_0000, 32'h3F80_0000, 32'h3F00_0000};
    dl = '{2, 3, 2, 2, 2, 0, 0, 0, 0, 3};

    {if0.in_valid, if0.out_ready, if1.in_valid, if1.out_ready} = '0;
    if0.x = '0;
    if1.x = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_y", if0.y, 32'h0);
    chk("rst_flags", {28'b0, if0.out_valid, if0.in_ready, if0.busy, 1'b0}, 32'h4);
    chk("rst_ops", if0.mul_a | if0.mul_b | if0.add_a | if0.add_b, 32'h0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run(if0, dx[i], dy[i], dl[i], $sformatf("dir%0d", i));

    // Backpressure: result must hold, new requests ignored, no accept in the handshake cycle.
    if0.out_ready = 1'b0;
    if0.in_valid  = 1'b1;
    if0.x         = 32'h3F00_0000;
    @(negedge clk);
    if0.x = 32'h4040_0000;
    lat = 0;
    while (if0.out_valid !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_lat", 32'(lat), 32'd2);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, if0.out_valid}, 32'd1);
      chk("bp_y", if0.y, 32'h3F20_0000);
      chk("bp_in_ready", {31'b0, if0.in_ready}, 32'd0);
    end
    if0.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {30'b0, if0.in_ready, if0.busy}, 32'h2);
    @(negedge clk);
    if0.in_valid = 1'b0;
    lat = 0;
    while (if0.out_valid !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_next_lat", 32'(lat), 32'd2);
    chk("bp_next_y", if0.y, 32'h3F70_0000);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      xv = rand_x();
      run(if0, xv, ref_y(xv), ref_lat(xv, M0, A0), $sformatf("rnd0_%0d_%h", i, xv));
    end

    // Longer latencies: operands must stay put for each whole wait window.
    if1.out_ready = 1'b1;
    if1.in_valid  = 1'b1;
    if1.x         = 32'h3F00_0000;
    @(negedge clk);
    if1.in_valid = 1'b0;
    repeat (M1) begin
      chk("w_mul_a", if1.mul_a, 32'h3F00_0000);
      chk("w_mul_b", if1.mul_b, 32'h3E80_0000);
      chk("w_mul_add", if1.add_a | if1.add_b, 32'h0);
      @(negedge clk);
    end
    repeat (A1) begin
      chk("w_add_a", if1.add_a, 32'h3E00_0000);
      chk("w_add_b", if1.add_b, 32'h3F00_0000);
      chk("w_add_mul", if1.mul_a | if1.mul_b, 32'h0);
      @(negedge clk);
    end
    chk("w_valid", {31'b0, if1.out_valid}, 32'd1);
    chk("w_y", if1.y, 32'h3F20_0000);
    @(negedge clk);

    run(if1, 32'hBF00_0000, 32'h3EC0_0000, M1 + 2 * A1, "neg_slow");
    for (int i = 0; i < 15; i++) begin
      xv = rand_x();
      run(if1, xv, ref_y(xv), ref_lat(xv, M1, A1), $sformatf("rnd1_%0d_%h", i, xv));
    end

    // Reset mid-multiply abandons the computation.
    if1.in_valid = 1'b1;
    if1.x        = 32'h3F80_0000;
    @(negedge clk);
    if1.in_valid = 1'b0;
    chk("mr_in_mul", if1.mul_a, 32'h3F80_0000);
    #2 rst1 = 1'b1;
    #1;
    chk("mr_ops", if1.mul_a | if1.mul_b | if1.add_a | if1.add_b, 32'h0);
    chk("mr_y", if1.y, 32'h0);
    chk("mr_flags", {29'b0, if1.out_valid, if1.in_ready, if1.busy}, 32'h2);
    @(negedge clk);
    rst1 = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (if1.out_valid === 1'b1) seen = 1'b1;
    end
    chk("mr_no_output", {31'b0, seen}, 32'd0);
    run(if1, 32'h4040_0000, 32'h3F70_0000, M1 + A1, "mr_resume");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
